// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: merges register-file writes from two requesters (A: control
// unit, B: loader/debug). It also runs a clear sequence that zeroes every register.
// The write port (enable/index/data/grant) is registered: the register file
// consumes it at the following edge.
// Optional feature: define ROUND_ROBIN_EN to alternate priority between A and B on
// conflict. When it is undefined, A always wins a conflict.
module reg_write_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              A_VALID,
    input  logic [ADDR_W-1:0] A_REG,
    input  logic [DATA_W-1:0] A_DATA,
    output logic              A_READY,
    input  logic              B_VALID,
    input  logic [ADDR_W-1:0] B_REG,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              B_READY,
    input  logic              CLR_REQ,
    output logic              CLR_BUSY,
    output logic              WRITEENABLE,
    output logic [ADDR_W-1:0] WRITEREG,
    output logic [DATA_W-1:0] WRITEDATA,
    output logic              GNT_B
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    localparam logic [ADDR_W-1:0] LastReg = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              gnt_b_q, gnt_b_d;
    logic              can_accept;
    logic              a_ready;
    logic              b_ready;
`ifdef ROUND_ROBIN_EN
    // 0: A holds priority, 1: B holds priority
    logic              ptr_b_q, ptr_b_d;
`endif

    // Grant decision: at most one ready. None is granted while clearing or when a
    // clear is requested.
    always_comb begin
        can_accept = (state_q == StIdle) && !CLR_REQ;
`ifdef ROUND_ROBIN_EN
        a_ready    = can_accept && A_VALID && (!B_VALID || !ptr_b_q);
        b_ready    = can_accept && B_VALID && (!A_VALID || ptr_b_q);
`else
        a_ready    = can_accept && A_VALID;
        b_ready    = can_accept && B_VALID && !A_VALID;
`endif
    end

    // Next state and next write-port contents. The clear index is loaded together with
    // the write register, so WRITEREG equals the counter in every CLEAR cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        gnt_b_d = 1'b0;
`ifdef ROUND_ROBIN_EN
        ptr_b_d = ptr_b_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (CLR_REQ) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    we_d    = 1'b1;
                    wreg_d  = '0;
                    wdata_d = '0;
                end else if (a_ready) begin
                    we_d    = 1'b1;
                    wreg_d  = A_REG;
                    wdata_d = A_DATA;
`ifdef ROUND_ROBIN_EN
                    ptr_b_d = 1'b1;
`endif
                end else if (b_ready) begin
                    we_d    = 1'b1;
                    wreg_d  = B_REG;
                    wdata_d = B_DATA;
                    gnt_b_d = 1'b1;
`ifdef ROUND_ROBIN_EN
                    ptr_b_d = 1'b0;
`endif
                end
            end
            StClear: begin
                // CLR_REQ is ignored here, so a re-request cannot extend the sequence
                if (cnt_q == LastReg) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    we_d    = 1'b1;
                    wreg_d  = cnt_q + 1'b1;
                    wdata_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State and write-port registers; a synchronous reset overrides everything.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            gnt_b_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
            ptr_b_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            gnt_b_q <= gnt_b_d;
`ifdef ROUND_ROBIN_EN
            ptr_b_q <= ptr_b_d;
`endif
        end
    end

    assign A_READY     = a_ready;
    assign B_READY     = b_ready;
    assign CLR_BUSY    = (state_q == StClear);
    assign WRITEENABLE = we_q;
    assign WRITEREG    = wreg_q;
    assign WRITEDATA   = wdata_q;
    assign GNT_B       = gnt_b_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_reg_write_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREG   = 1 << ADDR_W;
`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, b_valid, clr_req;
    logic [ADDR_W-1:0] a_reg, b_reg;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_ready, b_ready, clr_busy, we, gnt_b;
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] wdata;

    int checks = 0;
    int errors = 0;

    // Reference model: clear progress, the one write due on the port, priority owner
    bit              m_clearing;
    int              m_pos;
    bit              m_ptr_b;
    bit              m_lw_valid;
    bit              m_lw_b;
    int              m_lw_reg;
    int              m_lw_data;
    bit              exp_a_rdy, exp_b_rdy;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .A_VALID    (a_valid),
        .A_REG      (a_reg),
        .A_DATA     (a_data),
        .A_READY    (a_ready),
        .B_VALID    (b_valid),
        .B_REG      (b_reg),
        .B_DATA     (b_data),
        .B_READY    (b_ready),
        .CLR_REQ    (clr_req),
        .CLR_BUSY   (clr_busy),
        .WRITEENABLE(we),
        .WRITEREG   (wreg),
        .WRITEDATA  (wdata),
        .GNT_B      (gnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_clearing = 1'b0;
        m_pos      = 0;
        m_ptr_b    = 1'b0;
        m_lw_valid = 1'b0;
        m_lw_b     = 1'b0;
        m_lw_reg   = 0;
        m_lw_data  = 0;
    endtask

    // Who may write this cycle, from the arbitration rules
    task automatic model_ready();
        exp_a_rdy = 1'b0;
        exp_b_rdy = 1'b0;
        if (!m_clearing && !clr_req) begin
            if (a_valid && b_valid) begin
                if (RR && m_ptr_b) exp_b_rdy = 1'b1;
                else               exp_a_rdy = 1'b1;
            end else begin
                exp_a_rdy = a_valid;
                exp_b_rdy = b_valid;
            end
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (m_clearing) begin
            m_lw_valid = 1'b0;
            m_pos++;
            if (m_pos == NREG) begin
                m_clearing = 1'b0;
                m_pos      = 0;
            end
        end else if (clr_req) begin
            m_clearing = 1'b1;
            m_pos      = 0;
            m_lw_valid = 1'b0;
        end else if (exp_a_rdy) begin
            m_lw_valid = 1'b1;
            m_lw_b     = 1'b0;
            m_lw_reg   = int'(a_reg);
            m_lw_data  = int'(a_data);
            m_ptr_b    = 1'b1;
        end else if (exp_b_rdy) begin
            m_lw_valid = 1'b1;
            m_lw_b     = 1'b1;
            m_lw_reg   = int'(b_reg);
            m_lw_data  = int'(b_data);
            m_ptr_b    = 1'b0;
        end else begin
            m_lw_valid = 1'b0;
        end
    endtask

    // One clock: inputs are already applied; check readies/busy, clock, check write port
    task automatic step();
        bit exp_we, exp_gnt;
        int exp_reg, exp_data;
        #1;
        model_ready();
        check_eq("a_ready", {31'b0, a_ready}, {31'b0, exp_a_rdy});
        check_eq("b_ready", {31'b0, b_ready}, {31'b0, exp_b_rdy});
        check_eq("clr_busy", {31'b0, clr_busy}, {31'b0, m_clearing});
        model_edge();
        @(posedge clk);
        #1;
        exp_we   = 1'b0;
        exp_gnt  = 1'b0;
        exp_reg  = 0;
        exp_data = 0;
        if (m_clearing) begin
            exp_we  = 1'b1;
            exp_reg = m_pos;
        end else if (m_lw_valid) begin
            exp_we   = 1'b1;
            exp_gnt  = m_lw_b;
            exp_reg  = m_lw_reg;
            exp_data = m_lw_data;
        end
        check_eq("we", {31'b0, we}, {31'b0, exp_we});
        check_eq("gnt_b", {31'b0, gnt_b}, {31'b0, exp_gnt});
        if (exp_we) begin
            check_eq("wreg", 32'(wreg), exp_reg);
            check_eq("wdata", 32'(wdata), exp_data);
        end
    endtask

    task automatic idle_inputs();
        rst     = 1'b0;
        clr_req = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_reg   = '0;
        b_reg   = '0;
        a_data  = '0;
        b_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int  gseq;
        int  busy_len;
        bit  a_pend, b_pend;

        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_we", {31'b0, we}, 32'd0);
        check_eq("rst_wreg", 32'(wreg), 32'd0);
        check_eq("rst_wdata", 32'(wdata), 32'd0);
        check_eq("rst_gnt_b", {31'b0, gnt_b}, 32'd0);
        check_eq("rst_busy", {31'b0, clr_busy}, 32'd0);
        rst = 1'b0;

        // Single A write to r3
        a_valid = 1'b1;
        a_reg   = 3'd3;
        a_data  = 8'h33;
        step();
        check_eq("single_reg", 32'(wreg), 32'd3);
        check_eq("single_data", 32'(wdata), 32'h33);
        a_valid = 1'b0;
        step();
        check_eq("single_we_off", {31'b0, we}, 32'd0);

        // Both requesters valid for four cycles, pointer starting at A
        do_reset();
        a_valid = 1'b1; a_reg = 3'd1; a_data = 8'hAA;
        b_valid = 1'b1; b_reg = 3'd2; b_data = 8'hBB;
        gseq = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            gseq = (gseq << 1) | int'(gnt_b);
        end
        check_eq("conflict_gnt_seq", gseq, RR ? 32'b0101 : 32'b0000);
        idle_inputs();
        step();

        // Clear request with a same-cycle A request; A waits until IDLE
        a_valid = 1'b1; a_reg = 3'd5; a_data = 8'h5A;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < NREG; i++) step();
        check_eq("clr_a_ready_after", {31'b0, a_ready}, 32'd1);
        step();
        check_eq("clr_then_a_reg", 32'(wreg), 32'd5);
        a_valid = 1'b0;
        step();

        // Reset while clearing, in the cycle showing WRITEREG=3
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_eq("abort_at_reg3", 32'(wreg), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("abort_we", {31'b0, we}, 32'd0);
        check_eq("abort_busy", {31'b0, clr_busy}, 32'd0);
        step();

        // Clear re-requested mid-sequence: still eight busy cycles
        clr_req = 1'b1;
        step();
        clr_req  = 1'b0;
        busy_len = 0;
        for (int i = 0; i < 20; i++) begin
            if (clr_busy) busy_len++;
            clr_req = (busy_len == 5);
            step();
        end
        clr_req = 1'b0;
        check_eq("clear_len", busy_len, NREG);

        // Random traffic with holding requesters
        a_pend = 1'b0;
        b_pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            clr_req = ($urandom_range(0, 19) == 0);
            if (rst) begin
                a_pend = 1'b0;
                b_pend = 1'b0;
            end else begin
                if (!a_pend && $urandom_range(0, 1) == 1) begin
                    a_pend = 1'b1;
                    a_reg  = ADDR_W'($urandom);
                    a_data = DATA_W'($urandom);
                end
                if (!b_pend && $urandom_range(0, 1) == 1) begin
                    b_pend = 1'b1;
                    b_reg  = ADDR_W'($urandom);
                    b_data = DATA_W'($urandom);
                end
            end
            a_valid = a_pend;
            b_valid = b_pend;
            step();
            if (exp_a_rdy) a_pend = 1'b0;
            if (exp_b_rdy) b_pend = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
